pwm_compare_stage: RTL and testbench
====================================

Name: pwm_compare_stage

Overview:
- Downstream consumer of the free-running up-counter that wraps at a programmable limit.
- Compares the counter value against a double-buffered duty value and drives a registered PWM output.
- Duty updates are handshaken and take effect only at period boundaries.
- A start/stop state machine aligns output activity to whole counter periods.

Parameters:
- WIDTH, 8, width of counter value, limit and duty.
- DEAD, 2, dead-time in clk cycles; used only when DEADTIME_EN is defined; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock shared with the counter.
- reset  input  1  synchronous, active-high reset.
- cnt_q  input  WIDTH  current counter value.
- cnt_en  input  1  counter enable, same signal driving the counter.
- cnt_limit  input  WIDTH  counter limit, same value driving the counter.
- start  input  1  single-cycle request to begin PWM.
- stop  input  1  single-cycle request to end PWM after the current period.
- duty_in  input  WIDTH  new duty value (high-cycles per period).
- duty_valid  input  1  duty_in is valid.
- duty_ready  output  1  pending buffer is empty; a duty can be accepted.
- pwm_out  output  1  PWM output.
- pwm_out_n  output  1  complementary output; present only with DEADTIME_EN.
- busy  output  1  state is not IDLE.
- period_done  output  1  one-cycle pulse at the end of each active period.

Behaviour:
- Reset: all outputs and internal state are cleared.
  - pwm_out=0, pwm_out_n=0, period_done=0, busy=0, duty_ready=1.
  - active_duty=0, pending empty, state=IDLE.
- Wrap event W = cnt_en && (cnt_q == cnt_limit). This is the cycle in which the counter returns to 0 on the next edge.
- Duty buffering:
  - Accept when duty_valid && duty_ready: pending <= duty_in, pending full.
  - duty_ready = !pending_full, driven from a register (no combinational path from duty_valid).
  - On W with pending full: active_duty <= pending, pending empty, so duty_ready=1 on the next cycle.
  - Accept and W in the same cycle: only possible when pending is empty. W transfers nothing; the accepted value waits for the next W.
  - Buffer transfers occur in every state, including IDLE.
- FSM states IDLE, ARM, RUN, DRAIN:
  - IDLE: start -> ARM.
  - ARM: W -> RUN; stop -> IDLE.
  - RUN: stop -> DRAIN; start is ignored.
  - DRAIN: W -> IDLE; start and stop are ignored.
  - start and stop in the same cycle: stop wins (IDLE stays IDLE, ARM -> IDLE).
- Compare: raw = (state is RUN or DRAIN) && (cnt_q < active_duty), unsigned WIDTH-bit compare.
  - pwm_out <= raw, i.e. one cycle latency.
  - duty 0 -> constant low; duty > cnt_limit -> constant high.
  - cnt_en low: cnt_q holds, so the output holds its compare result.
- Duty timing: the W cycle compares with the old duty; the new duty applies from the following cycle (cnt_q=0).
- period_done <= W && state in {RUN, DRAIN}.
- busy is combinational from the state register.
- Reset mid-operation: a full clear on the next edge; any pending duty is discarded.

Optional Feature:
- Macro DEADTIME_EN.
- Defined:
  - pwm_out_n port exists.
  - pwm_out rises DEAD cycles after raw rises and falls on the same edge raw falls.
  - pwm_out_n rises DEAD cycles after raw falls (while active) and falls on the same edge raw rises.
  - Raw high or low phases shorter than or equal to DEAD suppress the corresponding output pulse.
  - pwm_out and pwm_out_n are never high simultaneously.
  - Both outputs are 0 in IDLE and ARM.
- Undefined: no pwm_out_n port, no dead-time logic; pwm_out is the registered raw.

Test Plan:
- Common setup for all scenarios: WIDTH=8, cnt_limit=9, cnt_en=1.
- Duty 4 accepted in IDLE, start -> after the first W, pwm_out is high 4 and low 6 of every 10 cycles; period_done pulses every 10 cycles.
- Running at duty 4, push 7 at cnt_q=3 -> duty_ready low until the cycle after W; current period stays 4 high, next period 7 high; a second push is not accepted while pending is full.
- Duty 0 -> pwm_out always 0; duty 10 and duty 255 -> pwm_out always 1 in RUN; period_done still pulses every 10 cycles.
- stop at cnt_q=2 -> period completes; busy=0 the cycle after W; pwm_out 0 from two cycles after W; start in the same cycle as stop is ignored.
- reset asserted at cnt_q=5 in RUN with pending full -> next cycle pwm_out=0, busy=0, duty_ready=1; a restart runs at duty 0.
- DEADTIME_EN, DEAD=2, duty 4 -> pwm_out high 2 cycles, pwm_out_n high 4 cycles per period, never overlapping; duty 2 -> pwm_out never high.

Source files
------------

// File: rtl/pwm_compare_stage.sv
// PWM compare stage: double-buffered duty compared against an external wrapping counter.
// Optional complementary output with dead-time insertion when DEADTIME_EN is defined.
module pwm_compare_stage #(
  parameter int WIDTH = 8,
  parameter int DEAD  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic             cnt_en,
  input  logic [WIDTH-1:0] cnt_limit,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
`ifdef DEADTIME_EN
  output logic             pwm_out_n,
`endif
  output logic             busy,
  output logic             period_done
);

  // state | meaning
  // IDLE  | output off, waiting for start
  // ARM   | start seen, waiting for a period boundary
  // RUN   | output active, period after period
  // DRAIN | stop seen, finishing the current period
  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] active_duty;
  logic [WIDTH-1:0] pending_duty;
  logic             pending_full;
  logic             wrap;
  logic             accept;
  logic             active;
  logic             raw;

  generate
    if (DEAD < 1 || DEAD > 15) begin : g_dead_range
      $error("pwm_compare_stage: DEAD must be in 1..15");
    end
  endgenerate

  assign wrap       = cnt_en && (cnt_q == cnt_limit);
  assign accept     = duty_valid && !pending_full;
  assign active     = (state == RUN) || (state == DRAIN);
  assign raw        = active && (cnt_q < active_duty);
  assign busy       = (state != IDLE);
  assign duty_ready = ~pending_full;

  // A wrap with a full buffer blocks acceptance, so the two branches never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_duty  <= '0;
      pending_duty <= '0;
      pending_full <= 1'b0;
    end else if (wrap && pending_full) begin
      active_duty  <= pending_duty;
      pending_full <= 1'b0;
    end else if (accept) begin
      pending_duty <= duty_in;
      pending_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      period_done <= 1'b0;
    end else begin
      period_done <= wrap && active;
      case (state)
        IDLE:    if (start && !stop) state <= ARM;
        ARM:     if (stop) state <= IDLE;
                 else if (wrap) state <= RUN;
        RUN:     if (stop) state <= DRAIN;
        DRAIN:   if (wrap) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEADTIME_EN
  localparam logic [3:0] DEAD_L = 4'(DEAD);

  // Run lengths of the current raw phase, saturating so long phases stay valid.
  logic [3:0] hi_run;
  logic [3:0] lo_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_run    <= '0;
      lo_run    <= '0;
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      if (raw)
        hi_run <= (hi_run == 4'hf) ? hi_run : hi_run + 4'd1;
      else
        hi_run <= '0;
      if (active && !raw)
        lo_run <= (lo_run == 4'hf) ? lo_run : lo_run + 4'd1;
      else
        lo_run <= '0;
      pwm_out   <= raw && (hi_run >= DEAD_L);
      pwm_out_n <= active && !raw && (lo_run >= DEAD_L);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) pwm_out <= 1'b0;
    else       pwm_out <= raw;
  end
`endif

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Directed bench for pwm_compare_stage: the bench plays the shared counter and
// keeps a cycle model whose expected outputs go through a scoreboard queue.
module tb_pwm_compare_stage;

  localparam logic [7:0] LIM = 8'd9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cnt_q = 8'd0;
  logic       cnt_en = 1'b1;
  logic [7:0] cnt_limit = LIM;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] duty_in = 8'd0;
  logic       duty_valid = 1'b0;
  logic       duty_ready;
  logic       pwm_out;
  logic       busy;
  logic       period_done;
`ifdef DEADTIME_EN
  logic       pwm_out_n;
`endif

  pwm_compare_stage #(.WIDTH(8), .DEAD(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .cnt_q       (cnt_q),
    .cnt_en      (cnt_en),
    .cnt_limit   (cnt_limit),
    .start       (start),
    .stop        (stop),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
`ifdef DEADTIME_EN
    .pwm_out_n   (pwm_out_n),
`endif
    .busy        (busy),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pwm;
    logic pd;
    logic busy;
    logic ready;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // model state: 0 IDLE, 1 ARM, 2 RUN, 3 DRAIN
  int         m_state = 0;
  logic [7:0] m_act = 8'd0;
  logic [7:0] m_pend = 8'd0;
  bit         m_pfull = 1'b0;

  logic last_pwm;
  logic last_pd;
  logic last_pn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit st, input bit sp, input bit dv, input logic [7:0] d,
                       input bit rs, input bit en);
    exp_t e;
    exp_t got;
    bit w, acc, run;
    int st_old;
    logic [7:0] act_old;
    start = st; stop = sp; duty_valid = dv; duty_in = d; reset = rs; cnt_en = en;
    if (rs) begin
      m_state = 0; m_act = 8'd0; m_pfull = 1'b0;
      e = '{pwm: 1'b0, pd: 1'b0, busy: 1'b0, ready: 1'b1};
    end else begin
      w = en && (cnt_q == LIM);
      acc = dv && !m_pfull;
      act_old = m_act;
      st_old = m_state;
      if (w && m_pfull) begin
        m_act = m_pend; m_pfull = 1'b0;
      end else if (acc) begin
        m_pend = d; m_pfull = 1'b1;
      end
      run = (st_old == 2) || (st_old == 3);
      case (st_old)
        0: if (st && !sp) m_state = 1;
        1: if (sp) m_state = 0; else if (w) m_state = 2;
        2: if (sp) m_state = 3;
        3: if (w) m_state = 0;
        default: m_state = 0;
      endcase
      e.pwm = run && (cnt_q < act_old);
      e.pd = w && run;
      e.busy = (m_state != 0);
      e.ready = !m_pfull;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
`ifndef DEADTIME_EN
    check("pwm_out", {31'd0, pwm_out}, {31'd0, got.pwm});
`else
    last_pn = pwm_out_n;
`endif
    check("period_done", {31'd0, period_done}, {31'd0, got.pd});
    check("busy", {31'd0, busy}, {31'd0, got.busy});
    check("duty_ready", {31'd0, duty_ready}, {31'd0, got.ready});
    last_pwm = pwm_out;
    last_pd = period_done;
    if (rs) cnt_q = 8'd0;
    else if (en) cnt_q = (cnt_q == LIM) ? 8'd0 : cnt_q + 8'd1;
    start = 1'b0; stop = 1'b0; duty_valid = 1'b0; reset = 1'b0; cnt_en = 1'b1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 8'd0, 0, 1);
  endtask

  task automatic push(input logic [7:0] d);
    cycle(0, 0, 1, d, 0, 1);
  endtask

  task automatic run_to(input logic [7:0] v);
    for (int i = 0; i < 40 && cnt_q != v; i++) idle();
    if (cnt_q != v) begin
      errors++;
      $error("FAIL run_to timeout observed=%0d expected=%0d", cnt_q, v);
    end
  endtask

  // One full period starting at cnt_q == 0: count high samples and period_done pulses.
  task automatic measure(input string tag, input int exp_hi);
    int hi = 0;
    int pdc = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (last_pwm) hi++;
      if (last_pd) pdc++;
    end
    check({tag, "_high"}, hi, exp_hi);
    check({tag, "_pd"}, pdc, 1);
  endtask

`ifdef DEADTIME_EN
  task automatic measure_dt(input string tag, input int exp_p, input int exp_n);
    int hp = 0;
    int hn = 0;
    int ov = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (last_pwm) hp++;
      if (last_pn) hn++;
      if (last_pwm && last_pn) ov++;
    end
    check({tag, "_p"}, hp, exp_p);
    check({tag, "_n"}, hn, exp_n);
    check({tag, "_overlap"}, ov, 0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cycle(0, 0, 0, 8'd0, 1, 1);
    cycle(0, 0, 0, 8'd0, 1, 1);
    check("rst_pwm", {31'd0, pwm_out}, 0);
    check("rst_ready", {31'd0, duty_ready}, 1);
`ifdef DEADTIME_EN
    check("rst_pwm_n", {31'd0, pwm_out_n}, 0);
    push(8'd4);
    cycle(1, 0, 0, 8'd0, 0, 1);
    run_to(LIM);
    idle();
    measure_dt("dt4", 2, 4);
    push(8'd2);
    run_to(LIM);
    idle();
    measure_dt("dt2", 0, 6);
`else
    // duty 4 accepted in IDLE, then start
    push(8'd4);
    check("ready_after_push", {31'd0, duty_ready}, 0);
    cycle(1, 0, 0, 8'd0, 0, 1);
    check("busy_arm", {31'd0, busy}, 1);
    run_to(LIM);
    idle();
    measure("d4a", 4);
    measure("d4b", 4);

    // mid-period update to 7, second push refused while pending is full
    run_to(8'd3);
    push(8'd7);
    check("ready_low_pending", {31'd0, duty_ready}, 0);
    push(8'd99);
    run_to(LIM);
    idle();
    check("ready_after_wrap", {31'd0, duty_ready}, 1);
    measure("d7", 7);

    // extremes
    push(8'd0);
    run_to(LIM);
    idle();
    measure("d0", 0);
    push(8'd10);
    run_to(LIM);
    idle();
    measure("d10", 10);
    push(8'd255);
    run_to(LIM);
    idle();
    measure("d255", 10);

    // back to 4, then hold the counter at cnt_q=2
    push(8'd4);
    run_to(LIM);
    idle();
    run_to(8'd2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'd0, 0, 0);
    check("hold_pwm", {31'd0, pwm_out}, 1);

    // stop with start in the same cycle at cnt_q=2
    cycle(1, 1, 0, 8'd0, 0, 1);
    check("busy_drain", {31'd0, busy}, 1);
    run_to(LIM);
    idle();
    check("drain_pd", {31'd0, period_done}, 1);
    check("busy_after_drain", {31'd0, busy}, 0);
    idle();
    check("pwm_after_drain", {31'd0, pwm_out}, 0);
    cycle(1, 1, 0, 8'd0, 0, 1);
    check("idle_start_stop", {31'd0, busy}, 0);

    // reset mid-run with pending full
    cycle(1, 0, 0, 8'd0, 0, 1);
    run_to(LIM);
    idle();
    run_to(8'd3);
    push(8'd8);
    run_to(8'd5);
    cycle(0, 0, 0, 8'd0, 1, 1);
    check("midrst_pwm", {31'd0, pwm_out}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_ready", {31'd0, duty_ready}, 1);
    cycle(1, 0, 0, 8'd0, 0, 1);
    run_to(LIM);
    idle();
    measure("restart_d0", 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
